spi_slave: RTL and testbench
============================

# spi_slave

SPI target (slave) endpoint, mode 0 (CPOL=0, CPHA=0), MSB first, that answers the team's SPI master on the same sck/cs/mosi/miso wires. All pin inputs are oversampled in the local clk domain. Each received word is delivered as a one-cycle rx_valid strobe. A single-entry holding register, filled through a valid/ready handshake, supplies the word returned on miso. The block sits at the peripheral side of the SPI link and feeds a register file or FIFO.

## Interface

- DATA_WIDTH, 8: bits per SPI word (≥2).
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- sck  input  1  SPI clock from master, asynchronous to clk.
- cs  input  1  chip select, active low, asynchronous.
- mosi  input  1  master-out data, asynchronous.
- miso  output  1  slave-out data.
- tx_data  input  DATA_WIDTH  next word to return to master.
- tx_valid  input  1  tx_data valid.
- tx_ready  output  1  holding register empty; a write occurs when tx_valid && tx_ready.
- rx_data  output  DATA_WIDTH  last complete received word; held until next word completes.
- rx_valid  output  1  one-cycle strobe when rx_data updates.
- tx_underrun  output  1  one-cycle strobe when a word load finds the holding register empty.
- busy  output  1  synchronized cs is low.

## Operation

- Synchronizers: two flops each on sck, cs, mosi, plus one history flop on sck and cs for edge detection. Reset values: sck chain 0, cs chain 1, mosi chain 0.
- FSM has two states:
  - IDLE: synchronized cs high.
  - ACTIVE: synchronized cs low.
  - IDLE→ACTIVE on cs falling edge. ACTIVE→IDLE on cs rising edge.
- Word load sources the TX shifter from the holding register and empties it. If the register is already empty, load all-zeros and pulse tx_underrun.
  - Loads happen on entry to ACTIVE.
  - Loads also happen on the first sck falling edge after a word completes.
- sck rising edge in ACTIVE:
  - rx_shift ← {rx_shift[W-2:0], mosi_sync}; bit_cnt++.
  - When bit_cnt reaches DATA_WIDTH: rx_data ← completed word; rx_valid pulses; bit_cnt ← 0; a word-load is armed for the next falling edge.
- sck falling edge in ACTIVE: perform the armed load if one is pending. Otherwise shift the TX shifter left by one, shifting in 0.
- miso = TX shifter MSB while ACTIVE; 0 in IDLE.
- Holding register: tx_ready = ~full.
  - tx_valid && tx_ready sets full and captures tx_data.
  - tx_valid while full is ignored and leaves the stored word unchanged.
  - A write and a load in the same cycle: the load takes the old contents (or underruns if empty). The new word stays stored and full stays 1.
- Abort: cs rising with 0 < bit_cnt < DATA_WIDTH discards the partial word.
  - No rx_valid; bit_cnt ← 0.
  - The TX shifter contents are dropped and never returned to the holding register.
  - The next transfer starts word-aligned.
- Edges of sck while in IDLE are ignored.
- rst low (any time, including mid-transfer) forces:
  - IDLE, bit_cnt 0, shifters 0, holding register empty.
  - Outputs: miso 0, tx_ready 1, rx_data 0, rx_valid 0, tx_underrun 0, busy 0.

## Timing

- Pin-to-action latency is 3 clk rising edges. A pin change before edge k is registered at k, k+1, and acted on at k+2. Outputs (miso, rx_valid, rx_data, busy, tx_underrun) change after edge k+2.
- First miso bit is valid 3 clk edges after cs falls. The master must not raise sck before that.
- sck high and low times must each be ≥ 4 clk periods (sck ≤ clk/8). The cs-low to first-sck setup must be ≥ 4 clk periods.
- rx_valid is high for exactly one cycle per completed word. rx_data is stable from that cycle until the next completion.
- tx_ready returns high in the cycle after the load that empties the holding register.
- Back-to-back words need no cs toggle. Refill the holding register before the falling sck edge that follows the last bit of the current word.

## Test plan

- Reset, tx 0x3C loaded, master sends 0xA5 with sck=clk/8 → rx_data=0xA5, one-cycle rx_valid, master captures 0x3C, tx_ready high after load, tx_underrun never pulses.
- Two words in one cs-low window, tx 0x11 then 0x22 written while tx_ready=1, master sends 0xF0, 0x0F → rx_valid pulses twice (0xF0, 0x0F), master receives 0x11, 0x22.
- No tx write, master sends 0xAA → master receives 0x00, tx_underrun pulses once at cs fall, rx_data=0xAA.
- cs raised after 5 sck cycles of 0xFF, then full transfer of 0x5A → no rx_valid for the partial word, second transfer gives rx_data=0x5A.
- tx_valid with 0x77 while full holding 0x3C → tx_ready=0, write ignored, master receives 0x3C.
- rst pulled low after bit 4 of a transfer → all outputs at reset values within one cycle, and the next full transfer of 0xC3 receives correctly.

Source files
------------

// File: rtl/spi_slave.sv
// SPI mode-0 target: oversampled sck/cs/mosi, MSB-first RX word strobe, single-entry TX holding register.
// Latency: pin change acted on 3 clk edges later; rx_valid is a 1-cycle strobe after the last sck rise.
// Backpressure: tx_ready low while the holding register is full; writes while full are ignored.
module spi_slave #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sck,
    input  logic                  cs,
    input  logic                  mosi,
    output logic                  miso,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  tx_underrun,
    output logic                  busy
);
    localparam int CW = $clog2(DATA_WIDTH);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t                state;
    logic [1:0]            sck_s, cs_s, mosi_s;
    logic                  sck_d, cs_d;
    logic [CW-1:0]         bit_cnt;
    logic                  load_pend;
    logic [DATA_WIDTH-2:0] rx_shift;
    logic [DATA_WIDTH-1:0] tx_shift;
    logic [DATA_WIDTH-1:0] hold;
    logic                  full;

    logic                  sck_rise, sck_fall, cs_rise, cs_fall;
    logic                  do_load;
    logic [DATA_WIDTH-1:0] rx_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sck_s  <= 2'b00;
            cs_s   <= 2'b11;
            mosi_s <= 2'b00;
            sck_d  <= 1'b0;
            cs_d   <= 1'b1;
        end else begin
            sck_s  <= {sck_s[0], sck};
            cs_s   <= {cs_s[0], cs};
            mosi_s <= {mosi_s[0], mosi};
            sck_d  <= sck_s[1];
            cs_d   <= cs_s[1];
        end
    end

    always_comb begin
        sck_rise = sck_s[1] & ~sck_d;
        sck_fall = ~sck_s[1] & sck_d;
        cs_rise  = cs_s[1] & ~cs_d;
        cs_fall  = ~cs_s[1] & cs_d;
        rx_next  = {rx_shift, mosi_s[1]};
        // A cs rise in the same cycle as the trailing sck fall ends the frame without consuming a word.
        do_load  = ((state == IDLE) && cs_fall) ||
                   ((state == ACTIVE) && !cs_rise && sck_fall && load_pend);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            load_pend   <= 1'b0;
            rx_shift    <= '0;
            tx_shift    <= '0;
            hold        <= '0;
            full        <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            busy        <= 1'b0;
        end else begin
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;

            if (do_load) begin
                tx_shift    <= full ? hold : '0;
                tx_underrun <= ~full;
                full        <= 1'b0;
            end
            // A write can only land while empty, so it always wins over a same-cycle load.
            if (tx_valid && !full) begin
                hold <= tx_data;
                full <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (cs_fall) begin
                        state     <= ACTIVE;
                        busy      <= 1'b1;
                        bit_cnt   <= '0;
                        load_pend <= 1'b0;
                    end
                end
                ACTIVE: begin
                    if (cs_rise) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        bit_cnt   <= '0;
                        load_pend <= 1'b0;
                        tx_shift  <= '0;
                    end else if (sck_rise) begin
                        rx_shift <= rx_next[DATA_WIDTH-2:0];
                        if (bit_cnt == CW'(DATA_WIDTH - 1)) begin
                            rx_data   <= rx_next;
                            rx_valid  <= 1'b1;
                            bit_cnt   <= '0;
                            load_pend <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else if (sck_fall) begin
                        if (load_pend) begin
                            load_pend <= 1'b0;
                        end else begin
                            tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign miso     = (state == ACTIVE) & tx_shift[DATA_WIDTH-1];
    assign tx_ready = ~full;

endmodule

// File: tb/tb_spi_slave.sv
// Scoreboarded bench for spi_slave: a mode-0 master model at sck = clk/8 drives directed words.
module tb_spi_slave;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         sck = 1'b0;
    logic         cs = 1'b1;
    logic         mosi = 1'b0;
    logic         miso;
    logic [W-1:0] tx_data = '0;
    logic         tx_valid = 1'b0;
    logic         tx_ready;
    logic [W-1:0] rx_data;
    logic         rx_valid;
    logic         tx_underrun;
    logic         busy;

    int           n_cmp = 0;
    int           n_bad = 0;
    int           ur_cnt = 0;
    logic         rx_prev = 1'b0;
    logic [W-1:0] exp_rx[$];

    spi_slave #(.DATA_WIDTH(W)) dut (
        .clk(clk), .rst(rst), .sck(sck), .cs(cs), .mosi(mosi), .miso(miso),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .tx_underrun(tx_underrun), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Monitor: every rx_valid pulse pops the next expected word.
    always @(negedge clk) begin
        if (rst && rx_valid) begin
            check("rx_valid_single_cycle", {31'd0, rx_prev}, 32'd0);
            if (exp_rx.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL rx_unexpected: got 0x%0h expected no rx_valid", rx_data);
            end else begin
                check("rx_data", {24'd0, rx_data}, {24'd0, exp_rx.pop_front()});
            end
        end
        if (rst && tx_underrun) ur_cnt++;
        rx_prev = rx_valid;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tx_write(input logic [W-1:0] d);
        int t = 0;
        while (!tx_ready && t < 50) begin
            tick(1);
            t++;
        end
        if (t >= 50) begin
            n_cmp++;
            n_bad++;
            $display("FAIL tx_ready_timeout: got 0 expected 1 within 50 cycles");
        end
        tx_valid = 1'b1;
        tx_data  = d;
        tick(1);
        tx_valid = 1'b0;
    endtask

    task automatic cs_down();
        cs = 1'b0;
        tick(4);
    endtask

    // Master samples miso just before raising sck; the final fall coincides with cs rising.
    task automatic send_word(input logic [W-1:0] w, input int nbits, input bit end_cs,
                             output logic [W-1:0] got);
        got = '0;
        for (int i = 0; i < nbits; i++) begin
            mosi = w[W-1-i];
            tick(4);
            got = {got[W-2:0], miso};
            sck = 1'b1;
            tick(4);
            sck = 1'b0;
            if (end_cs && i == nbits - 1) cs = 1'b1;
        end
        if (end_cs) tick(8);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_miso"}, {31'd0, miso}, 32'd0);
        check({tag, "_tx_ready"}, {31'd0, tx_ready}, 32'd1);
        check({tag, "_rx_data"}, {24'd0, rx_data}, 32'd0);
        check({tag, "_rx_valid"}, {31'd0, rx_valid}, 32'd0);
        check({tag, "_tx_underrun"}, {31'd0, tx_underrun}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        logic [W-1:0] g1, g2;
        int ur0;

        #2 rst = 1'b0;
        tick(3);
        check_reset_outputs("rst0");
        rst = 1'b1;
        tick(4);

        // Single word with preloaded reply.
        ur0 = ur_cnt;
        tx_write(8'h3C);
        check("t1_tx_ready_full", {31'd0, tx_ready}, 32'd0);
        cs_down();
        check("t1_busy", {31'd0, busy}, 32'd1);
        check("t1_tx_ready_after_load", {31'd0, tx_ready}, 32'd1);
        exp_rx.push_back(8'hA5);
        send_word(8'hA5, 8, 1'b1, g1);
        check("t1_miso_word", {24'd0, g1}, 32'h3C);
        check("t1_underruns", ur_cnt - ur0, 32'd0);
        check("t1_busy_end", {31'd0, busy}, 32'd0);

        // Two back-to-back words in one cs window.
        ur0 = ur_cnt;
        tx_write(8'h11);
        exp_rx.push_back(8'hF0);
        exp_rx.push_back(8'h0F);
        cs_down();
        tx_write(8'h22);
        send_word(8'hF0, 8, 1'b0, g1);
        send_word(8'h0F, 8, 1'b1, g2);
        check("t2_miso_word0", {24'd0, g1}, 32'h11);
        check("t2_miso_word1", {24'd0, g2}, 32'h22);
        check("t2_underruns", ur_cnt - ur0, 32'd0);

        // No reply written: zeros returned, one underrun at cs fall.
        ur0 = ur_cnt;
        exp_rx.push_back(8'hAA);
        cs_down();
        send_word(8'hAA, 8, 1'b1, g1);
        check("t3_miso_word", {24'd0, g1}, 32'h00);
        check("t3_underruns", ur_cnt - ur0, 32'd1);
        check("t3_rx_data_held", {24'd0, rx_data}, 32'hAA);

        // Aborted partial word, then a realigned full word.
        ur0 = ur_cnt;
        cs_down();
        send_word(8'hFF, 5, 1'b1, g1);
        exp_rx.push_back(8'h5A);
        cs_down();
        send_word(8'h5A, 8, 1'b1, g1);
        check("t4_miso_word", {24'd0, g1}, 32'h00);
        check("t4_underruns", ur_cnt - ur0, 32'd2);
        check("t4_rx_data", {24'd0, rx_data}, 32'h5A);

        // Write while full is ignored.
        ur0 = ur_cnt;
        tx_write(8'h3C);
        tx_valid = 1'b1;
        tx_data  = 8'h77;
        check("t5_tx_ready_while_full", {31'd0, tx_ready}, 32'd0);
        tick(2);
        tx_valid = 1'b0;
        exp_rx.push_back(8'h96);
        cs_down();
        send_word(8'h96, 8, 1'b1, g1);
        check("t5_miso_word", {24'd0, g1}, 32'h3C);
        check("t5_tx_ready_after", {31'd0, tx_ready}, 32'd1);
        check("t5_underruns", ur_cnt - ur0, 32'd0);

        // Reset mid-transfer, then a clean transfer.
        cs_down();
        tx_write(8'h5A);
        send_word(8'hC3, 4, 1'b0, g1);
        rst = 1'b0;
        #1;
        check_reset_outputs("t6_rst");
        cs = 1'b1;
        sck = 1'b0;
        tick(2);
        rst = 1'b1;
        tick(4);
        ur0 = ur_cnt;
        tx_write(8'h96);
        exp_rx.push_back(8'hC3);
        cs_down();
        send_word(8'hC3, 8, 1'b1, g1);
        check("t6_miso_word", {24'd0, g1}, 32'h96);
        check("t6_rx_data", {24'd0, rx_data}, 32'hC3);
        check("t6_underruns", ur_cnt - ur0, 32'd0);

        check("rx_queue_drained", exp_rx.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
